// File: rtl/threewire_arbiter.sv
// threewire_arbiter: round-robin sharing of one three-wire serial master among NUM_REQ requesters
// Ports: in_clk clock; in_rst synchronous active-high reset.
//   Requester side: in_req/in_r_w level request and direction (1=write), in_addr/in_wr_data packed
//   per requester; out_grant one-hot owner, out_done one-cycle completion pulse, out_err timeout flag,
//   out_rd_data read result valid with out_done.
//   Master side: out_m_r_w/out_m_addr/out_m_wr_data latched command, out_m_start held until busy,
//   in_m_busy transfer in progress, in_m_rd_data read result.
// Optional: define THREEWIRE_ARB_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES cycles.
module threewire_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_BITS      = 9,
   parameter int DATA_BITS      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                           in_clk,
   input  logic                           in_rst,
   input  logic [NUM_REQ-1:0]             in_req,
   input  logic [NUM_REQ-1:0]             in_r_w,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   in_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   in_wr_data,
   output logic [NUM_REQ-1:0]             out_grant,
   output logic [NUM_REQ-1:0]             out_done,
   output logic                           out_err,
   output logic [DATA_BITS-1:0]           out_rd_data,
   output logic                           out_m_r_w,
   output logic [ADDR_BITS-1:0]           out_m_addr,
   output logic [DATA_BITS-1:0]           out_m_wr_data,
   output logic                           out_m_start,
   input  logic                           in_m_busy,
   input  logic [DATA_BITS-1:0]           in_m_rd_data
);
   localparam int PW = $clog2(NUM_REQ);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2;
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("threewire_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end
   logic [1:0]           r_state;
   logic [PW-1:0]        r_ptr, r_win, w_win, w_off, w_next_ptr;
   logic [PW:0]          w_sum;
   logic [NUM_REQ-1:0]   w_elig, w_rot, r_grant, r_done;
   logic                 w_found, w_rw, w_end, w_tout;
   logic [ADDR_BITS-1:0] w_addr, r_m_addr;
   logic [DATA_BITS-1:0] w_wd, r_m_wr_data, r_rd_data;
   logic                 r_m_r_w, r_m_start;
   // the requester just serviced is masked for the done cycle so a held request cannot win twice in a row
   assign w_elig = in_req & ~r_done;
   // rotate eligibility so bit 0 is the pointer position; the lowest set bit is the winner's offset
   assign w_rot = NUM_REQ'({w_elig, w_elig} >> r_ptr);
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = PW'(k);
         end
   end
   assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win      = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : PW'(w_sum);
   assign w_next_ptr = (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
   always_comb begin
      w_rw   = 1'b0;
      w_addr = '0;
      w_wd   = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (w_win == PW'(k)) begin
            w_rw   = in_r_w[k];
            w_addr = in_addr[k*ADDR_BITS +: ADDR_BITS];
            w_wd   = in_wr_data[k*DATA_BITS +: DATA_BITS];
         end
   end
`ifdef THREEWIRE_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_err;
   // counter runs from the grant edge, so the abort lands TIMEOUT_CYCLES edges after grant
   assign w_tout = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge in_clk) begin
      r_cnt <= (in_rst || r_state == IDLE) ? '0 : r_cnt + 1'b1;
      r_err <= !in_rst && w_tout;
   end
   assign out_err = r_err;
`else
   assign w_tout  = 1'b0;
   assign out_err = 1'b0;
`endif
   assign w_end = w_tout || (r_state == WAIT && !in_m_busy);
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_win       <= '0;
         r_grant     <= '0;
         r_done      <= '0;
         r_rd_data   <= '0;
         r_m_r_w     <= 1'b0;
         r_m_addr    <= '0;
         r_m_wr_data <= '0;
         r_m_start   <= 1'b0;
      end else begin
         r_done <= '0;
         if (w_end) begin
            r_rd_data <= (w_tout || r_m_r_w) ? '0 : in_m_rd_data;
            r_done    <= r_grant;
            r_grant   <= '0;
            r_m_start <= 1'b0;
            r_ptr     <= w_next_ptr;
            r_state   <= IDLE;
         end else if (r_state == START && in_m_busy) begin
            // the master only samples start on its divided ticks, so start is held until busy shows
            r_m_start <= 1'b0;
            r_state   <= WAIT;
         end else if (r_state == IDLE && w_found) begin
            r_grant     <= NUM_REQ'(1) << w_win;
            r_win       <= w_win;
            r_m_r_w     <= w_rw;
            r_m_addr    <= w_addr;
            r_m_wr_data <= w_wd;
            r_m_start   <= 1'b1;
            r_state     <= START;
         end
      end
   end
   assign out_grant     = r_grant;
   assign out_done      = r_done;
   assign out_rd_data   = r_rd_data;
   assign out_m_r_w     = r_m_r_w;
   assign out_m_addr    = r_m_addr;
   assign out_m_wr_data = r_m_wr_data;
   assign out_m_start   = r_m_start;
endmodule

// File: tb/tb_threewire_arbiter.sv
// tb_threewire_arbiter: directed and randomized check of threewire_arbiter against a behavioural model
module tb_threewire_arbiter;
   localparam int N = 4;
   logic          in_clk = 1'b0;
   logic          in_rst = 1'b1;
   logic [N-1:0]  in_req = '0, in_r_w = '0;
   logic [N*9-1:0]  in_addr = '0;
   logic [N*16-1:0] in_wr_data = '0;
   logic [N-1:0]  out_grant, out_done;
   logic          out_err, out_m_r_w, out_m_start;
   logic [15:0]   out_rd_data, out_m_wr_data;
   logic [8:0]    out_m_addr;
   logic          m_busy = 1'b0;
   logic [15:0]   m_rd = '0;
   int            m_cnt = 0;
   bit            m_hang = 1'b0;
   logic [8:0]    m_a;
   logic          m_rw;
   logic [15:0]   m_wd;
   logic [15:0]   mm [512];
   bit            mm_v [512];
   logic [15:0]   rm [512];
   int            n_chk = 0, n_fail = 0, ref_ptr = 0, prev_done = -1;

   threewire_arbiter #(.NUM_REQ(N), .ADDR_BITS(9), .DATA_BITS(16), .TIMEOUT_CYCLES(64)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req), .in_r_w(in_r_w), .in_addr(in_addr),
      .in_wr_data(in_wr_data), .out_grant(out_grant), .out_done(out_done), .out_err(out_err),
      .out_rd_data(out_rd_data), .out_m_r_w(out_m_r_w), .out_m_addr(out_m_addr),
      .out_m_wr_data(out_m_wr_data), .out_m_start(out_m_start), .in_m_busy(m_busy),
      .in_m_rd_data(m_rd));

   always #5 in_clk = ~in_clk;

   function automatic logic [15:0] init_val(input logic [8:0] a);
      return (a == 9'h1A5) ? 16'hBEEF : (16'(a) * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // master model: accepts start, busy rises 4 clocks later and falls 100 clocks after that
   always @(posedge in_clk) begin
      if (m_cnt != 0) begin
         m_cnt <= (m_cnt == 104) ? 0 : m_cnt + 1;
         if (m_cnt == 4) m_busy <= 1'b1;
         if (m_cnt == 104) begin
            m_busy <= 1'b0;
            if (m_rw) begin
               mm[m_a]   <= m_wd;
               mm_v[m_a] <= 1'b1;
            end else m_rd <= mm_v[m_a] ? mm[m_a] : init_val(m_a);
         end
      end else if (out_m_start && !m_hang) begin
         m_cnt <= 1;
         m_a   <= out_m_addr;
         m_rw  <= out_m_r_w;
         m_wd  <= out_m_wr_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] e);
      for (int k = 0; k < N; k++)
         if (e[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
      return 0;
   endfunction

   task automatic setreq(input int i, input logic rw, input logic [8:0] a, input logic [15:0] d);
      in_r_w[i] = rw;
      in_addr[i*9 +: 9] = a;
      in_wr_data[i*16 +: 16] = d;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge in_clk);
      prev_done = -1;
   endtask

   // one complete transfer; mode 0: drop request on done, 1: keep it, 2: drop right after grant
   task automatic xfer(input int mode, output int w);
      logic [N-1:0] elig, oh;
      logic         rw;
      logic [8:0]   a;
      logic [15:0]  wd, erd;
      bit           hold_ok, start_ok, seen;
      int           n;
      elig = in_req;
      if (prev_done >= 0) elig[prev_done] = 1'b0;
      if (elig == '0) begin
         @(negedge in_clk);
         chk("masked_gap_grant", out_grant, 0);
         elig = in_req;
      end
      w   = pick(elig);
      oh  = N'(1) << w;
      rw  = in_r_w[w];
      a   = in_addr[w*9 +: 9];
      wd  = in_wr_data[w*16 +: 16];
      erd = rw ? 16'h0 : rm[a];
      if (rw) rm[a] = wd;
      @(negedge in_clk);
      chk("grant", out_grant, oh);
      chk("start_on_grant", out_m_start, 1);
      chk("done_off_at_grant", out_done, 0);
      chk("m_r_w", out_m_r_w, rw);
      chk("m_addr", out_m_addr, a);
      chk("m_wr_data", out_m_wr_data, wd);
      in_addr[w*9 +: 9] = 9'($urandom);
      in_wr_data[w*16 +: 16] = 16'($urandom);
      if (mode == 2) in_req[w] = 1'b0;
      hold_ok = 1; start_ok = 1; seen = 0; n = 0;
      while (out_done == '0 && n < 400) begin
         if (out_grant !== oh || out_m_addr !== a || out_m_r_w !== rw || out_m_wr_data !== wd) hold_ok = 0;
         if (out_m_start !== !seen) start_ok = 0;
         if (m_busy) seen = 1;
         @(negedge in_clk);
         n++;
      end
      chk("latched_stable", hold_ok, 1);
      chk("start_held_until_busy", start_ok, 1);
      chk("busy_seen", seen, 1);
      chk("done", out_done, oh);
      chk("grant_clear_at_done", out_grant, 0);
      chk("rd_data", out_rd_data, erd);
      chk("err", out_err, 0);
      chk("start_off_at_done", out_m_start, 0);
      ref_ptr   = (w + 1) % N;
      prev_done = w;
      if (mode == 0) in_req[w] = 1'b0;
   endtask

   initial begin
      int w, n;
      bit ok;
      for (int i = 0; i < 512; i++) rm[i] = init_val(9'(i));
      repeat (3) @(negedge in_clk);
      chk("rst_grant", out_grant, 0);
      chk("rst_done", out_done, 0);
      chk("rst_err", out_err, 0);
      chk("rst_rd", out_rd_data, 0);
      chk("rst_start", out_m_start, 0);
      chk("rst_m_addr", out_m_addr, 0);
      chk("rst_m_r_w", out_m_r_w, 0);
      chk("rst_m_wr_data", out_m_wr_data, 0);
      in_rst = 1'b0;
      idle(2);
      // single read from requester 1
      setreq(1, 1'b0, 9'h1A5, 16'h0);
      in_req = 4'b0010;
      xfer(0, w);
      chk("single_read_owner", w, 1);
      chk("single_read_data", out_rd_data, 16'hBEEF);
      idle(1);
      chk("done_one_cycle", out_done, 0);
      // single write from requester 2, request dropped early, then read back via requester 3
      setreq(2, 1'b1, 9'h033, 16'h1234);
      in_req = 4'b0100;
      xfer(2, w);
      chk("single_write_owner", w, 2);
      chk("single_write_rd_zero", out_rd_data, 0);
      idle(2);
      setreq(3, 1'b0, 9'h033, 16'h0);
      in_req = 4'b1000;
      xfer(0, w);
      chk("readback", out_rd_data, 16'h1234);
      // contention: all four held, each drops on its done
      idle(2);
      for (int i = 0; i < N; i++) setreq(i, i[0], 9'(9'h1A0 + i), 16'(16'hA000 + i));
      in_req = 4'b1111;
      for (int i = 0; i < N; i++) begin
         xfer(0, w);
         chk("contention_order", w, i);
      end
      idle(2);
      for (int i = 0; i < N; i++) setreq(i, 1'b0, 9'(9'h1A4 + i), 16'h0);
      in_req = 4'b1111;
      xfer(0, w);
      chk("reraise_first", w, 0);
      while (in_req != '0) xfer(0, w);
      // fairness: 0 and 3 held permanently
      idle(2);
      in_req = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         xfer(1, w);
         chk("fair_alternate", w, (i % 2 == 0) ? 0 : 3);
      end
      in_req = '0;
      // reset mid-WAIT; first leave the pointer at 2
      idle(2);
      setreq(1, 1'b0, 9'h010, 16'h0);
      in_req = 4'b0010;
      xfer(0, w);
      idle(2);
      setreq(2, 1'b0, 9'h011, 16'h0);
      in_req = 4'b0100;
      repeat (30) @(negedge in_clk);
      chk("pre_reset_grant", out_grant, 4'b0100);
      in_rst = 1'b1;
      in_req = '0;
      @(negedge in_clk);
      in_rst = 1'b0;
      chk("midrst_grant", out_grant, 0);
      chk("midrst_start", out_m_start, 0);
      chk("midrst_done", out_done, 0);
      chk("midrst_rd", out_rd_data, 0);
      chk("midrst_m_addr", out_m_addr, 0);
      ref_ptr = 0;
      n = 0;
      while (m_cnt != 0 && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      chk("master_idle_after_rst", m_cnt, 0);
      idle(2);
      setreq(1, 1'b0, 9'h012, 16'h0);
      setreq(3, 1'b0, 9'h013, 16'h0);
      in_req = 4'b1010;
      xfer(0, w);
      chk("ptr_zero_after_rst", w, 1);
      xfer(0, w);
      // master never answers
      idle(2);
      m_hang = 1'b1;
      setreq(1, 1'b0, 9'h0F0, 16'h0);
      in_req = 4'b0010;
      @(negedge in_clk);
      chk("hang_grant", out_grant, 4'b0010);
`ifdef THREEWIRE_ARB_TIMEOUT_EN
      n = 0;
      while (out_done == '0 && n < 200) begin
         @(negedge in_clk);
         n++;
      end
      chk("timeout_cycles", n, 64);
      chk("timeout_done", out_done, 4'b0010);
      chk("timeout_err", out_err, 1);
      chk("timeout_start", out_m_start, 0);
      chk("timeout_rd", out_rd_data, 0);
      chk("timeout_grant", out_grant, 0);
      in_req = '0;
      m_hang = 1'b0;
      @(negedge in_clk);
      chk("timeout_err_pulse", out_err, 0);
      chk("timeout_done_pulse", out_done, 0);
      ref_ptr = 2;
`else
      ok = 1;
      repeat (200) begin
         @(negedge in_clk);
         if (out_m_start !== 1'b1 || out_done !== '0 || out_err !== 1'b0) ok = 0;
      end
      chk("hang_waits", ok, 1);
      m_hang = 1'b0;
      n = 0;
      while (out_done == '0 && n < 300) begin
         @(negedge in_clk);
         n++;
      end
      chk("hang_recover_done", out_done, 4'b0010);
      chk("hang_recover_rd", out_rd_data, rm[9'h0F0]);
      in_req = '0;
      ref_ptr = 2;
`endif
      // randomized batches
      for (int r = 0; r < 10; r++) begin
         idle(1 + $urandom_range(0, 3));
         for (int i = 0; i < N; i++)
            setreq(i, 1'($urandom), 9'(9'h1A0 + $urandom_range(0, 15)), 16'($urandom));
         in_req = N'($urandom_range(1, 15));
         while (in_req != '0) xfer(($urandom_range(0, 3) == 0) ? 2 : 0, w);
      end
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $fatal(1, "FAIL watchdog: simulation did not finish");
   end
endmodule
